// File: rtl/ordering_xfer_ctrl.sv
// Ordering transfer sequencer: expands one host load/unload command into
// (cmd_num+1)*NODE_NUM beats to/from the node ordering registers, with a
// credit-limited read path and a first-word fall-through read buffer.
module ordering_xfer_ctrl #(
  parameter int NODE_NUM     = 32,
  parameter int CITY_DIV_LOG = 4,
  parameter int RD_LAT       = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [CITY_DIV_LOG-1:0] cmd_num,
  input  logic                    abort,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [63:0]             wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [63:0]             rd_data,
  output logic [CITY_DIV_LOG-1:0] ordering_num,
  output logic                    ordering_write,
  output logic                    ordering_read,
  output logic [63:0]             ordering_wdata,
  input  logic [63:0]             ordering_rdata,
  input  logic                    ordering_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int NODE_W = (NODE_NUM > 1) ? $clog2(NODE_NUM) : 1;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CITY_DIV_LOG-1:0] word_cnt;
  logic [NODE_W-1:0]       node_cnt;
  logic [RD_LAT-1:0]       vld_sr;
  logic [63:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_count, inflight;
  logic                    accept, flush, beat, rd_beat, last_beat;
  logic                    push, pop, fifo_empty, credit_ok, drain_done;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept     = (state == IDLE) && cmd_valid;
  assign flush      = abort && (state != IDLE);
  assign beat       = (ordering_write || ordering_read) && ordering_ready;
  assign rd_beat    = ordering_read && ordering_ready;
  assign last_beat  = (word_cnt == ordering_num) && (node_cnt == NODE_W'(NODE_NUM - 1));
  assign inflight   = CW'($countones(vld_sr));
  assign credit_ok  = (fifo_count + inflight) < CW'(FIFO_DEPTH);
  assign push       = vld_sr[RD_LAT-1];
  assign fifo_empty = (fifo_count == '0);
  assign rd_valid   = !fifo_empty;
  assign rd_data    = fifo_empty ? '0 : mem[rd_ptr];
  assign pop        = rd_valid && rd_ready;
  // With inflight==0 nothing can be pushed, so only the pop matters here.
  assign drain_done = (inflight == '0) && (fifo_empty || ((fifo_count == CW'(1)) && pop));
  assign ordering_wdata = wr_data;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and node/host handshake outputs.
  always_comb begin
    state_nxt      = state;
    cmd_ready      = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    wr_ready       = 1'b0;
    ordering_write = 1'b0;
    ordering_read  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = cmd_write ? WRITE : READ;
      end
      WRITE: begin
        ordering_write = wr_valid;
        wr_ready       = ordering_ready;
        if (wr_valid && ordering_ready && last_beat) state_nxt = DONE;
      end
      READ: begin
        ordering_read = credit_ok;
        if (credit_ok && ordering_ready && last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Command latch and word/node beat counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ordering_num <= '0;
      word_cnt     <= '0;
      node_cnt     <= '0;
    end else if (flush) begin
      word_cnt <= '0;
      node_cnt <= '0;
    end else if (accept) begin
      ordering_num <= cmd_num;
      word_cnt     <= '0;
      node_cnt     <= '0;
    end else if (beat) begin
      if (word_cnt == ordering_num) begin
        word_cnt <= '0;
        node_cnt <= node_cnt + 1'b1;
      end else begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  // Read-latency valid pipeline; the top bit marks ordering_rdata to capture.
  always_ff @(posedge clk) begin
    if (reset || flush) vld_sr <= '0;
    else                vld_sr <= (vld_sr << 1) | RD_LAT'(rd_beat);
  end

  // Read buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Read buffer storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ordering_rdata;
  end

endmodule

// File: tb/tb_ordering_xfer_ctrl.sv
// Directed bench for ordering_xfer_ctrl with a latency-accurate node model.
module tb_ordering_xfer_ctrl;

  localparam int NN  = 4;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic        clk, reset, cmd_valid, cmd_ready, cmd_write, abort;
  logic [3:0]  cmd_num, ordering_num;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [63:0] wr_data, rd_data, ordering_wdata, ordering_rdata;
  logic        ordering_write, ordering_read, ordering_ready, busy, done;

  ordering_xfer_ctrl #(.NODE_NUM(NN), .CITY_DIV_LOG(4), .RD_LAT(LAT), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_num(cmd_num), .abort(abort),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ordering_num(ordering_num), .ordering_write(ordering_write),
    .ordering_read(ordering_read), .ordering_wdata(ordering_wdata),
    .ordering_rdata(ordering_rdata), .ordering_ready(ordering_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, hidx = 0, wbeats = 0, rd_issued = 0, rd_popped = 0, done_n = 0;
  bit saw_wr = 0;
  int due_q[$];
  logic [63:0] dat_q[$];

  typedef struct {
    logic rdy, wv;
    logic exp_write, exp_wr_ready, exp_done, exp_busy;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [63:0] hword(input int k);
    return {32'hC0DE_0000 | 32'(k), 32'h0000_1000 + 32'(k * 7)};
  endfunction

  function automatic logic [63:0] rword(input int k);
    return {32'h5EED_0000 | 32'(k), 32'hF00D_0000 ^ 32'(k * 3 + 5)};
  endfunction

  assign wr_data = hword(hidx);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [3:0] n);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_num   = n;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag, input logic [3:0] num);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_ord_read"}, ordering_read, 0);
    chk({tag, "_ord_write"}, ordering_write, 0);
    chk({tag, "_ord_num"}, ordering_num, num);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask

  task automatic clear_counts();
    hidx = 0; wbeats = 0; rd_issued = 0; rd_popped = 0; done_n = 0; saw_wr = 0;
  endtask

  // Node model: returns rword(i) for the i-th read beat exactly LAT cycles later.
  initial begin
    ordering_rdata = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      while (due_q.size() > 0 && due_q[0] < cyc) begin
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        ordering_rdata = dat_q.pop_front();
      end else begin
        ordering_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end
  end

  // Beat/host monitor: write order, credit bound, read order, done pulses.
  initial forever begin
    @(negedge clk);
    if (ordering_write && ordering_ready) begin
      chk("wdata_order", ordering_wdata, hword(wbeats));
      wbeats++;
    end
    if (wr_valid && wr_ready) hidx++;
    if (ordering_read && ordering_ready) begin
      due_q.push_back(cyc + LAT);
      dat_q.push_back(rword(rd_issued));
      rd_issued++;
      chk_int("read_credit", (rd_issued - rd_popped <= DEP) ? 1 : 0, 1);
    end
    if (rd_valid && rd_ready) begin
      chk("rdata_order", rd_data, rword(rd_popped));
      rd_popped++;
    end
    if (done) done_n++;
    if (ordering_write) saw_wr = 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fv, fp, lp, np, dk, bk, rv;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_num = '0; abort = 1'b0;
    wr_valid = 1'b0; rd_ready = 1'b0; ordering_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk_idle("reset", 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Streaming write, 2 words x 4 nodes.
    clear_counts();
    ordering_ready = 1'b1; wr_valid = 1'b1;
    issue(1'b1, 4'd1);
    dk = 0; bk = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("wr_busy_first", busy, 1);
        chk("wr_ord_num", ordering_num, 4'd1);
        chk("wr_first_req", ordering_write, 1);
      end
      if (done && dk == 0) dk = k;
      if (!busy && bk == 0) bk = k;
      @(posedge clk); #1;
    end
    chk_int("wr_beats", wbeats, 8);
    chk_int("wr_done_cycle", dk, 9);
    chk_int("wr_done_count", done_n, 1);
    chk_int("wr_busy_low_cycle", bk, 10);
    wr_valid = 1'b0;

    // Write with ordering_ready toggling and one host bubble, table-driven.
    clear_counts();
    issue(1'b1, 4'd0);
    for (int i = 0; i < 10; i++) begin
      ordering_ready = tbl[i].rdy;
      wr_valid       = tbl[i].wv;
      @(negedge clk);
      chk($sformatf("tbl%0d_ord_write", i), ordering_write, tbl[i].exp_write);
      chk($sformatf("tbl%0d_wr_ready", i), wr_ready, tbl[i].exp_wr_ready);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].exp_done);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      @(posedge clk); #1;
    end
    chk_int("tbl_beats", wbeats, 4);
    chk_int("tbl_host_words", hidx, 4);
    wr_valid = 1'b0; ordering_ready = 1'b1;

    // Read with host stalled: credit limits issue to the buffer depth.
    clear_counts();
    rd_ready = 1'b0;
    issue(1'b0, 4'd1);
    fv = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rd_valid && fv == 0) fv = k;
      @(posedge clk); #1;
    end
    chk_int("rd_stalled_beats", rd_issued, 4);
    chk_int("rd_valid_rise_cycle", fv, 1 + LAT + 1);
    @(negedge clk);
    chk("rd_stall_ord_read", ordering_read, 0);
    chk("rd_stall_busy", busy, 1);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    fp = 0; lp = 0; np = 0; dk = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rd_valid && rd_ready) begin
        if (fp == 0) fp = k;
        lp = k;
        np++;
      end
      if (done) dk = k;
      @(posedge clk); #1;
    end
    chk_int("rd_total_beats", rd_issued, 8);
    chk_int("rd_total_pops", rd_popped, 8);
    chk_int("rd_sustained", lp - fp + 1, np);
    chk_int("rd_done_after_pop", dk, lp + 1);
    chk_int("rd_done_count", done_n, 1);
    rd_ready = 1'b0;

    // Abort in READ with two beats in flight and one word buffered.
    clear_counts();
    issue(1'b0, 4'd1);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(negedge clk);
    chk("abort_pre_rd_valid", rd_valid, 1);
    chk("abort_pre_ord_read", ordering_read, 1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk_idle("abort", 4'd1);
    rv = 0;
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (rd_valid || busy) rv++;
    end
    chk_int("abort_quiet", rv, 0);
    chk_int("abort_no_done", done_n, 0);
    @(posedge clk); #1;
    clear_counts();
    wr_valid = 1'b1;
    issue(1'b1, 4'd0);
    dk = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) dk = k;
      @(posedge clk); #1;
    end
    chk_int("post_abort_beats", wbeats, 4);
    chk_int("post_abort_done_cycle", dk, 5);
    chk_int("post_abort_done_count", done_n, 1);

    // Reset in the middle of a write.
    clear_counts();
    issue(1'b1, 4'd1);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_idle("midreset", 4'd0);
    @(posedge clk); #1;
    chk_int("midreset_beats", wbeats, 3);
    reset = 1'b0; abort = 1'b0; wr_valid = 1'b0;

    // cmd_valid pulsed while draining is ignored.
    clear_counts();
    rd_ready = 1'b1;
    issue(1'b0, 4'd0);
    lp = 0; dk = 0;
    for (int k = 1; k <= 14; k++) begin
      cmd_valid = (k == 5 || k == 6);
      cmd_write = 1'b1;
      cmd_num   = 4'd3;
      @(negedge clk);
      if (k == 5) begin
        chk("drain_busy", busy, 1);
        chk("drain_no_read", ordering_read, 0);
        chk("drain_cmd_ready", cmd_ready, 0);
      end
      if (rd_valid && rd_ready) lp = k;
      if (done) dk = k;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk_int("drain_pops", rd_popped, 4);
    chk_int("drain_done_count", done_n, 1);
    chk_int("drain_last_pop", lp, 7);
    chk_int("drain_done_cycle", dk, lp + 1);
    chk_int("drain_no_write", saw_wr ? 1 : 0, 0);
    chk("drain_num_kept", ordering_num, 4'd0);
    chk("drain_end_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
